// File: rtl/sico_play_stream_adapter.sv
// sico_play_stream_adapter: turns a tag-toggled, level-held SiCo player channel
// into a valid/ready word stream through a small FIFO.  Rev 1.0
`default_nettype none

module sico_play_stream_adapter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WIDTH:0]           val_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   level;
  logic             last_tag;

  logic tag;
  logic tag_known;
  logic toggle;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign tag = val_i[WIDTH];

  // An unknown tag means the player has not started yet; only a resolved 0/1 counts.
  always_comb begin
    tag_known = 1'b0;
    if ((tag == 1'b0) || (tag == 1'b1)) tag_known = 1'b1;
  end

  assign toggle = tag_known && (tag != last_tag);
  assign full   = (level == FULL_LEVEL);
  assign pop    = (level != '0) && ready_i;
  assign push   = toggle && (!full || pop);
  assign drop   = toggle && full && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      last_tag   <= 1'b0;
      overflow_o <= 1'b0;
      drop_cnt_o <= 16'h0000;
    end else begin
      if (toggle) last_tag <= tag;
      if (push) begin
        mem[wr_ptr] <= val_i[WIDTH-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'h0001;
      end
    end
  end

  assign data_o  = mem[rd_ptr];
  assign valid_o = (level != '0);
  assign level_o = level;

endmodule

`default_nettype wire

// File: tb/tb_sico_play_stream_adapter.sv
// Directed, table-driven bench for sico_play_stream_adapter (WIDTH=8, DEPTH=4).
`default_nettype none

module tb_sico_play_stream_adapter;

  logic        clk;
  logic        rst;
  logic [8:0]  val;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sico_play_stream_adapter #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .val_i      (val),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .level_o    (level),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tag_x;
    logic       tag;
    logic [7:0] payload;
    logic       rdy;
    logic       e_valid;
    logic       chk_data;
    logic [7:0] e_data;
    logic [2:0] e_level;
    logic       e_ovf;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic chk_data,
                           input logic [7:0] e_data, input logic [2:0] e_level,
                           input logic e_ovf, input logic [15:0] e_drop);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".level"}, {29'd0, level}, {29'd0, e_level});
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
    check({tag, ".drop"}, {16'd0, drop_cnt}, {16'd0, e_drop});
    if (chk_data) check({tag, ".data"}, {24'd0, data}, {24'd0, e_data});
  endtask

  task automatic add(input logic tx, input logic t, input logic [7:0] p, input logic r,
                     input logic ev, input logic cd, input logic [7:0] ed,
                     input logic [2:0] el, input logic eo, input logic [15:0] edr);
    vec_t v;
    v.tag_x = tx; v.tag = t; v.payload = p; v.rdy = r;
    v.e_valid = ev; v.chk_data = cd; v.e_data = ed;
    v.e_level = el; v.e_ovf = eo; v.e_drop = edr;
    vecs.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // tag_x tag payload rdy | valid chkdata data level ovf drop
    for (int i = 0; i < 5; i++) add(1, 0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0, 16'd0);
    add(0, 1, 8'hA5, 1, 1, 1, 8'hA5, 3'd1, 0, 16'd0);
    add(0, 1, 8'hA5, 1, 0, 0, 8'h00, 3'd0, 0, 16'd0);
    add(0, 0, 8'h01, 0, 1, 1, 8'h01, 3'd1, 0, 16'd0);
    add(0, 1, 8'h02, 0, 1, 1, 8'h01, 3'd2, 0, 16'd0);
    add(0, 0, 8'h03, 0, 1, 1, 8'h01, 3'd3, 0, 16'd0);
    add(0, 1, 8'h04, 0, 1, 1, 8'h01, 3'd4, 0, 16'd0);
    add(0, 0, 8'h05, 0, 1, 1, 8'h01, 3'd4, 1, 16'd1);
    add(0, 1, 8'h06, 0, 1, 1, 8'h01, 3'd4, 1, 16'd2);
    add(0, 0, 8'h77, 1, 1, 1, 8'h02, 3'd4, 1, 16'd2);
    add(0, 0, 8'h77, 1, 1, 1, 8'h03, 3'd3, 1, 16'd2);
    add(0, 0, 8'h77, 1, 1, 1, 8'h04, 3'd2, 1, 16'd2);
    add(0, 0, 8'h77, 1, 1, 1, 8'h77, 3'd1, 1, 16'd2);
    add(0, 0, 8'h77, 1, 0, 0, 8'h00, 3'd0, 1, 16'd2);

    rst   = 1'b1;
    ready = 1'b0;
    val   = {1'bx, 8'h00};
    #1;
    check_all("reset", 0, 1, 8'h00, 3'd0, 0, 16'd0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      val   = vecs[i].tag_x ? {1'bx, vecs[i].payload} : {vecs[i].tag, vecs[i].payload};
      ready = vecs[i].rdy;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].chk_data,
                vecs[i].e_data, vecs[i].e_level, vecs[i].e_ovf, vecs[i].e_drop);
    end

    // Constant value for 20 cycles yields exactly one word.
    val   = {1'b1, 8'h5A};
    ready = 1'b1;
    step();
    check_all("hold.first", 1, 1, 8'h5A, 3'd1, 1, 16'd2);
    for (int i = 1; i < 20; i++) begin
      step();
      check_all($sformatf("hold%0d", i), 0, 0, 8'h00, 3'd0, 1, 16'd2);
    end

    // Fill to three words, then reset asynchronously mid-cycle.
    ready = 1'b0;
    val = {1'b0, 8'h11}; step();
    val = {1'b1, 8'h22}; step();
    val = {1'b0, 8'h33}; step();
    check_all("prefill", 1, 1, 8'h11, 3'd3, 1, 16'd2);
    @(negedge clk);
    rst = 1'b1;
    val = {1'b1, 8'h44};
    #1;
    check_all("async_rst", 0, 1, 8'h00, 3'd0, 0, 16'd0);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    check_all("post_rst", 1, 1, 8'h44, 3'd1, 0, 16'd0);
    step();
    check_all("post_rst.hold", 1, 1, 8'h44, 3'd1, 0, 16'd0);
    ready = 1'b1;
    step();
    check_all("post_rst.pop", 0, 0, 8'h00, 3'd0, 0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
